// File: rtl/div_wb_merger_pkg.sv
// div_wb_merger_pkg: shared widths and FIFO entry layout for the divider writeback path
// Entry layout is {result, rd, pc, inst}, packed MSB first.
package div_wb_merger_pkg;
   localparam int REG_SIZE = 5;
   localparam int XLEN = 32;
   localparam int DIV_WB_DEPTH = 4;
   function automatic int entry_w(input int xlen);
      return 3 * xlen + REG_SIZE;
   endfunction
   localparam int ENTRY_W = entry_w(XLEN);
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: synchronous FIFO with async active-low reset, exposing each slot's rd and valid bit
module wb_result_fifo
   import div_wb_merger_pkg::*;
#(
   parameter int W = ENTRY_W,
   parameter int DEPTH = DIV_WB_DEPTH,
   parameter int RD_LSB = 2 * XLEN
)(
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              push,
   input  logic                              pop,
   input  logic [W-1:0]                      din,
   output logic [W-1:0]                      dout,
   output logic [$clog2(DEPTH):0]            count,
   output logic                              full,
   output logic                              empty,
   output logic [DEPTH-1:0][REG_SIZE-1:0]    rds,
   output logic [DEPTH-1:0]                  vld
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign do_pop = pop & ~empty;
   // a pop in the same cycle frees the slot, so a full FIFO can still accept
   assign do_push = push & (~full | do_pop);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop) rp <= rp + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wp] <= din;
   assign dout = mem[rp];
   for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      logic [AW-1:0] off;
      assign off = AW'(g) - rp;
      assign vld[g] = {1'b0, off} < count;
      assign rds[g] = mem[g][RD_LSB +: REG_SIZE];
   end
endmodule

// File: rtl/div_wb_merger.sv
// div_wb_merger: merges buffered divider results into idle W-stage write/retire slots
// Define DIV_WB_BYPASS_EN for zero-latency bypass when the FIFO is empty and W is idle.
module div_wb_merger
   import div_wb_merger_pkg::*;
#(
   parameter int DEPTH = DIV_WB_DEPTH,
   parameter int XLEN = div_wb_merger_pkg::XLEN
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                div_valid,
   input  logic [XLEN-1:0]     div_result,
   input  logic [REG_SIZE-1:0] div_rd,
   input  logic [XLEN-1:0]     div_pc,
   input  logic [XLEN-1:0]     div_inst,
   input  logic                wb_valid,
   input  logic                wb_we,
   input  logic [REG_SIZE-1:0] wb_rd,
   input  logic [XLEN-1:0]     wb_data,
   input  logic [XLEN-1:0]     wb_pc,
   input  logic [XLEN-1:0]     wb_inst,
   output logic                rf_we,
   output logic [REG_SIZE-1:0] rf_rd,
   output logic [XLEN-1:0]     rf_wdata,
   output logic                retire_valid,
   output logic [XLEN-1:0]     retire_pc,
   output logic [XLEN-1:0]     retire_inst,
   output logic                div_block,
   output logic [31:0]         pending_mask,
   output logic                overflow_err
);
   localparam int EW = entry_w(XLEN);
   localparam int AW = $clog2(DEPTH);
   logic [EW-1:0] head;
   logic [AW:0] count;
   logic full, empty, push, pop, byp;
   logic [DEPTH-1:0][REG_SIZE-1:0] rds;
   logic [DEPTH-1:0] vld;
   logic [XLEN-1:0] h_result, h_pc, h_inst;
   logic [REG_SIZE-1:0] h_rd;
   assign {h_result, h_rd, h_pc, h_inst} = head;
`ifdef DIV_WB_BYPASS_EN
   assign byp = div_valid & empty & ~wb_valid;
`else
   assign byp = 1'b0;
`endif
   assign pop = ~wb_valid & ~empty;
   assign push = div_valid & ~byp;
   wb_result_fifo #(.W(EW), .DEPTH(DEPTH), .RD_LSB(2 * XLEN)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
      .din({div_result, div_rd, div_pc, div_inst}), .dout(head),
      .count(count), .full(full), .empty(empty), .rds(rds), .vld(vld)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) overflow_err <= 1'b0;
      else if (push & full & ~pop) overflow_err <= 1'b1;
   always_comb begin
      rf_rd = wb_valid ? wb_rd : byp ? div_rd : h_rd;
      rf_wdata = wb_valid ? wb_data : byp ? div_result : h_result;
      retire_pc = wb_valid ? wb_pc : byp ? div_pc : h_pc;
      retire_inst = wb_valid ? wb_inst : byp ? div_inst : h_inst;
      rf_we = rst_n & (wb_valid ? wb_we : byp | ~empty) & (rf_rd != '0);
      retire_valid = rst_n & (wb_valid | byp | ~empty);
   end
   // one slot stays free for the result that may already be inside the divider
   assign div_block = count >= (AW+1)'(DEPTH - 1);
   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) pending_mask[rds[i]] = pending_mask[rds[i]] | vld[i];
      pending_mask[0] = 1'b0;
   end
endmodule

// File: tb/tb_div_wb_merger.sv
// tb_div_wb_merger: scoreboard bench with a queue-based reference model of the merger
module tb_div_wb_merger;
   localparam int DEPTH = 4;
`ifdef DIV_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic clk = 0, rst_n = 0;
   logic div_valid, wb_valid, wb_we;
   logic [31:0] div_result, div_pc, div_inst, wb_data, wb_pc, wb_inst;
   logic [4:0] div_rd, wb_rd, rf_rd;
   logic rf_we, retire_valid, div_block, overflow_err;
   logic [31:0] rf_wdata, retire_pc, retire_inst, pending_mask;
   typedef struct packed {logic we; logic [4:0] rd; logic [31:0] data, pc, inst;} ret_t;
   typedef struct packed {logic ret; logic blk; logic [31:0] mask; logic ovf;} st_t;
   typedef struct packed {logic [4:0] rd; logic [31:0] data, pc, inst;} ent_t;
   ret_t rq[$];
   st_t sq[$];
   ent_t mq[$];
   bit movf, run;
   int tests, fails;
   st_t ms;
   ret_t mr;

   div_wb_merger #(.DEPTH(DEPTH), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .div_valid(div_valid), .div_result(div_result),
      .div_rd(div_rd), .div_pc(div_pc), .div_inst(div_inst), .wb_valid(wb_valid),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc), .wb_inst(wb_inst),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .retire_valid(retire_valid),
      .retire_pc(retire_pc), .retire_inst(retire_inst), .div_block(div_block),
      .pending_mask(pending_mask), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   task automatic step(input bit wv, input bit we, input logic [4:0] wrd,
                       input bit dv, input logic [4:0] drd, input logic [31:0] dd);
      logic [31:0] m;
      bit bp;
      ent_t e;
      @(posedge clk);
      #1;
      wb_valid = wv; wb_we = we; wb_rd = wrd;
      wb_data = $urandom; wb_pc = $urandom; wb_inst = $urandom;
      div_valid = dv; div_rd = drd; div_result = dd;
      div_pc = $urandom; div_inst = $urandom;
      m = '0;
      foreach (mq[i]) m[mq[i].rd] = 1'b1;
      m[0] = 1'b0;
      bp = BYP && dv && !wv && mq.size() == 0;
      sq.push_back('{ret: wv || mq.size() > 0 || bp, blk: mq.size() >= DEPTH - 1, mask: m, ovf: movf});
      if (wv) rq.push_back('{we: we && wrd != 0, rd: wrd, data: wb_data, pc: wb_pc, inst: wb_inst});
      else if (mq.size() > 0) begin
         e = mq.pop_front();
         rq.push_back('{we: e.rd != 0, rd: e.rd, data: e.data, pc: e.pc, inst: e.inst});
      end else if (bp) rq.push_back('{we: drd != 0, rd: drd, data: dd, pc: div_pc, inst: div_inst});
      if (dv && !bp) begin
         if (mq.size() < DEPTH) mq.push_back('{rd: drd, data: dd, pc: div_pc, inst: div_inst});
         else movf = 1'b1;
      end
   endtask

   always @(negedge clk)
      if (rst_n && run && sq.size() > 0) begin
         ms = sq.pop_front();
         chk("retire_valid", 32'(retire_valid), 32'(ms.ret));
         chk("div_block", 32'(div_block), 32'(ms.blk));
         chk("pending_mask", pending_mask, ms.mask);
         chk("overflow_err", 32'(overflow_err), 32'(ms.ovf));
         if (retire_valid) begin
            if (rq.size() == 0) chk("retire_extra", 32'(retire_valid), 32'd0);
            else begin
               mr = rq.pop_front();
               chk("rf_we", 32'(rf_we), 32'(mr.we));
               chk("rf_rd", 32'(rf_rd), 32'(mr.rd));
               chk("rf_wdata", rf_wdata, mr.data);
               chk("retire_pc", retire_pc, mr.pc);
               chk("retire_inst", retire_inst, mr.inst);
            end
         end
      end

   initial begin
      wb_valid = 1; wb_we = 1; wb_rd = 5'd3; wb_data = 32'h1; wb_pc = 32'h2; wb_inst = 32'h3;
      div_valid = 1; div_rd = 5'd4; div_result = 32'h5; div_pc = 32'h6; div_inst = 32'h7;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_retire_valid", 32'(retire_valid), 32'd0);
      chk("rst_div_block", 32'(div_block), 32'd0);
      chk("rst_pending_mask", pending_mask, 32'd0);
      chk("rst_overflow_err", 32'(overflow_err), 32'd0);
      wb_valid = 0; div_valid = 0;
      @(negedge clk);
      rst_n = 1;
      run = 1;
      step(0, 0, 0, 1, 5'd5, 32'h7);
      step(0, 0, 0, 0, 0, 0);
      step(1, 1, 5'd1, 1, 5'd6, 32'h66);
      step(1, 1, 5'd2, 0, 0, 0);
      step(1, 1, 5'd3, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 5'd0, 32'h99);
      step(0, 0, 0, 0, 0, 0);
      step(1, 1, 5'd0, 0, 0, 0);
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
              mq.size() < DEPTH - 1 && $urandom_range(0, 2) == 0,
              $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
      repeat (6) step(0, 0, 0, 0, 0, 0);
      step(1, 1, 5'd1, 1, 5'd10, 32'hA0);
      step(1, 1, 5'd2, 1, 5'd11, 32'hA1);
      step(1, 1, 5'd3, 1, 5'd12, 32'hA2);
      step(1, 1, 5'd4, 1, 5'd13, 32'hA3);
      step(0, 0, 0, 1, 5'd14, 32'hA4);
      step(1, 1, 5'd5, 0, 0, 0);
      step(1, 1, 5'd6, 1, 5'd15, 32'hA5);
      repeat (6) step(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", rq.size(), 0);
      chk("status_drained", sq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/div_wb_merger.md
# div_wb_merger

Receiving end of the divider result path. Accepts fixed-latency results (data, rd, pc, inst, valid) emitted by the divider unit and merges them onto the single register-file write port and retire-trace port, alongside normal W-stage writebacks. The divider cannot be back-pressured, so results are buffered in a small FIFO and drained into idle W-stage write slots. A block signal feeds the hazard unit so that a new divide is not issued when the FIFO cannot absorb its result.

## Interface
Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- XLEN, 32, data/pc/inst width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- div_valid  in  1  divider result valid this cycle; single-cycle pulse per result
- div_result  in  XLEN  quotient or remainder
- div_rd  in  5  destination register
- div_pc  in  XLEN  pc of the divide instruction
- div_inst  in  XLEN  encoding of the divide instruction
- wb_valid  in  1  W-stage instruction retiring this cycle
- wb_we  in  1  W-stage register write enable
- wb_rd  in  5  W-stage destination register
- wb_data  in  XLEN  W-stage write data
- wb_pc  in  XLEN  W-stage pc
- wb_inst  in  XLEN  W-stage instruction encoding
- rf_we  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- retire_valid  out  1  retire-trace strobe
- retire_pc  out  XLEN  retired pc
- retire_inst  out  XLEN  retired instruction
- div_block  out  1  to hazard unit: do not issue a new divide
- pending_mask  out  32  one bit per rd held in the FIFO (bit 0 always 0)
- overflow_err  out  1  sticky flag: a result was dropped

## Operation
- Write port priority: W stage first. When wb_valid=1, the outputs are driven from the wb_* inputs: rf_we=wb_we & (wb_rd≠0) and retire_valid=1.
- When wb_valid=0 and the FIFO is non-empty, the FIFO head drives the outputs: rf_we=(head.rd≠0), retire_valid=1. The head is popped on that same clock edge.
- Enqueue: div_valid=1 pushes {result, rd, pc, inst} at the tail.
- Simultaneous push and pop is always legal, including when the FIFO is full.
- Push when full with no pop: the entry is dropped, overflow_err sets, and the FIFO contents are unchanged.
- overflow_err clears only on reset.
- div_block = (count ≥ DEPTH−1). This reserves one slot for the single result that can be in flight inside the divider.
- pending_mask: OR of the one-hot decodes of every valid FIFO entry's rd, with bit 0 forced to 0. It is combinational from registered FIFO state.
- Writes to x0 are suppressed (rf_we=0) but still retire.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.

## Timing
- Reset (async, rst_n=0):
  - FIFO is emptied (pointers=0, count=0).
  - overflow_err=0, div_block=0, pending_mask=0.
  - rf_we=0 and retire_valid=0 regardless of the inputs.
- Outputs are combinational from the wb_* inputs and the registered FIFO head. No added latency on the W path.
- Divider result latency, without bypass: push at edge N; the earliest write is in cycle N+1 if wb_valid=0 in that cycle.
- Reset deasserted mid-stream: entries in flight at reset are lost; no recovery is required.
- A continuous stream of wb_valid=1 starves the FIFO indefinitely. The hazard unit relies on div_block to bound this.

## Configuration
- DIV_WB_BYPASS_EN defined: when div_valid=1, the FIFO is empty and wb_valid=0, the div_* inputs drive the write and retire outputs in the same cycle and nothing is pushed (zero-cycle latency).
- DIV_WB_BYPASS_EN undefined: every result is pushed and written no earlier than the next cycle.
- All other behaviour is identical in both builds.

## Structure
- Shared package/defines: REG_SIZE, XLEN, DIV_WB_DEPTH default, and the FIFO entry layout as a packed {result, rd, pc, inst} width constant.
- One sub-module: wb_result_fifo.
  - Generic synchronous FIFO with async active-low reset.
  - Ports: push, pop, din, dout, count, full, empty, plus exposure of valid entries' rd fields for pending_mask.
- The merge mux, block logic and overflow flag live in div_wb_merger.

## Test plan
- Reset: hold rst_n=0 with wb_valid=1 and div_valid=1 → rf_we=0, retire_valid=0, div_block=0, pending_mask=0.
- Idle slot: div_valid with result 0x0000_0007, rd=5, wb_valid=0.
  - Without bypass: rf_we=1, rf_rd=5, rf_wdata=7 in the next cycle.
  - With bypass: same values in the same cycle.
- Contention: div result (rd=6) arrives while wb_valid=1 for 3 cycles (rd=1,2,3).
  - W-stage writes occur first in those 3 cycles.
  - The div result writes in cycle 4.
  - pending_mask=0x40 throughout the wait.
- Fill with DEPTH=4: hold wb_valid=1 and push 3 results.
  - div_block rises after the 3rd push.
  - A 4th push makes the FIFO full.
  - A 5th push without a pop sets overflow_err.
  - Drain order matches push order.
- Full push+pop: FIFO full, wb_valid=0, div_valid=1 → head pops, new entry is accepted, count stays 4, overflow_err stays 0.
- x0 destination: div result with rd=0 → retire_valid=1, rf_we=0, pending_mask bit 0 stays 0.
